ssd_scan_mux: RTL and testbench

//  - Downstream of the two-digit hex 7-segment decoder.
//  - Time-multiplexes the two decoded digit patterns (display, display_1) onto one shared segment bus.
//  - Drives two digit enables, with a dead-time blank between digits to prevent ghosting.
//  - Latches both patterns once per frame so a frame never shows a torn value.

---
 rtl/ssd_scan_mux.sv | 132 +++++++++++++
 tb/tb_ssd_scan_mux.sv | 136 +++++++++++++
 2 files changed

// File: rtl/ssd_scan_mux.sv
// Two-digit 7-segment scan multiplexer with dead-time blanking and per-frame pattern latch.
// Optional build macro SSD_LEADING_ZERO_BLANK_EN suppresses a left digit showing hex 0.
module ssd_scan_mux #(
  parameter int REFRESH_DIV    = 50000,
  parameter int BLANK_CYCLES   = 500,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] display,
  input  logic [6:0] display_1,
  output logic [6:0] seg_out,
  output logic [1:0] an_out,
  output logic       frame_tick
);

  typedef enum logic [1:0] {S_D0, S_B0, S_D1, S_B1} state_e;

  localparam int MAX_DUR = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CNT_W   = (MAX_DUR > 1) ? $clog2(MAX_DUR) : 1;
  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);
  localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(HAS_BLANK ? BLANK_CYCLES - 1 : 0);
  localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic [1:0] AN_OFF  = {2{AN_ACTIVE_LOW}};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       shadow0_q, shadow0_d;
  logic [6:0]       shadow1_q, shadow1_d;
  logic [6:0]       seg_q, seg_d;
  logic [1:0]       an_q, an_d;
  logic             tick_q, tick_d;
  logic             latch;
  logic [6:0]       seg_lg;
  logic [1:0]       an_lg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_D0;
      cnt_q     <= '0;
      shadow0_q <= 7'h00;
      shadow1_q <= 7'h00;
      seg_q     <= SEG_OFF;
      an_q      <= AN_OFF;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shadow0_q <= shadow0_d;
      shadow1_q <= shadow1_d;
      seg_q     <= seg_d;
      an_q      <= an_d;
      tick_q    <= tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    tick_d  = 1'b0;
    seg_lg  = 7'h00;
    an_lg   = 2'b00;

    // Both patterns are captured together at frame start so the frame cannot tear.
    latch     = en && (state_q == S_D0) && (cnt_q == '0);
    shadow0_d = latch ? display   : shadow0_q;
    shadow1_d = latch ? display_1 : shadow1_q;

    case (state_q)
      S_D0: begin
        seg_lg = shadow0_d;
        an_lg  = 2'b01;
        if (cnt_q == REF_LAST) begin
          state_d = HAS_BLANK ? S_B0 : S_D1;
          cnt_d   = '0;
        end
      end
      S_B0: begin
        if (cnt_q == BLK_LAST) begin
          state_d = S_D1;
          cnt_d   = '0;
        end
      end
      S_D1: begin
        seg_lg = shadow1_q;
        an_lg  = 2'b10;
`ifdef SSD_LEADING_ZERO_BLANK_EN
        if (shadow1_q == 7'b0111111) begin
          seg_lg = 7'h00;
          an_lg  = 2'b00;
        end
`endif
        if (cnt_q == REF_LAST) begin
          state_d = HAS_BLANK ? S_B1 : S_D0;
          tick_d  = !HAS_BLANK;
          cnt_d   = '0;
        end
      end
      S_B1: begin
        if (cnt_q == BLK_LAST) begin
          state_d = S_D0;
          tick_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = S_D0;
        cnt_d   = '0;
      end
    endcase

    // Disable aborts the frame: dark outputs, no tick, restart from a fresh latch.
    if (!en) begin
      state_d = S_D0;
      cnt_d   = '0;
      tick_d  = 1'b0;
      seg_lg  = 7'h00;
      an_lg   = 2'b00;
    end

    seg_d = SEG_ACTIVE_LOW ? ~seg_lg : seg_lg;
    an_d  = AN_ACTIVE_LOW  ? ~an_lg  : an_lg;
  end

  assign seg_out    = seg_q;
  assign an_out     = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_ssd_scan_mux.sv
// Randomized bench for ssd_scan_mux: one blanked active-low instance and one
// unblanked active-high instance, both checked against a frame-position model.
module tb_ssd_scan_mux;
  localparam int R  = 4;
  localparam int B0 = 2;
  localparam int B1 = 0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [6:0] display = 7'h00;
  logic [6:0] display_1 = 7'h00;
  logic [6:0] seg_a, seg_b;
  logic [1:0] an_a, an_b;
  logic       tick_a, tick_b;

  int n_checks = 0;
  int n_fail   = 0;

  int         ph_a = 0, ph_b = 0;
  logic [6:0] s0_a = 0, s1_a = 0, s0_b = 0, s1_b = 0;
  logic [6:0] es_a, es_b;
  logic [1:0] ea_a, ea_b;
  logic       et_a, et_b;

  always #5 clk = ~clk;

  ssd_scan_mux #(.REFRESH_DIV(R), .BLANK_CYCLES(B0), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) u_a (
    .clk(clk), .rst(rst), .en(en), .display(display), .display_1(display_1),
    .seg_out(seg_a), .an_out(an_a), .frame_tick(tick_a));

  ssd_scan_mux #(.REFRESH_DIV(R), .BLANK_CYCLES(B1), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) u_b (
    .clk(clk), .rst(rst), .en(en), .display(display), .display_1(display_1),
    .seg_out(seg_b), .an_out(an_b), .frame_tick(tick_b));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Frame position decides everything: [0,R) right digit, [R,R+blank) dark,
  // [R+blank,2R+blank) left digit, remainder dark; tick on the final position.
  task automatic model_step(input int blank, input bit seg_al, input bit an_al,
                            inout int ph, inout logic [6:0] s0, inout logic [6:0] s1,
                            output logic [6:0] es, output logic [1:0] ea, output logic et);
    int fr, pos;
    logic [6:0] sl;
    logic [1:0] al;
    fr = 2 * (R + blank);
    sl = 7'h00;
    al = 2'b00;
    et = 1'b0;
    if (!en) begin
      ph = 0;
    end else begin
      pos = ph % fr;
      if (pos == 0) begin
        s0 = display;
        s1 = display_1;
      end
      if (pos < R) begin
        sl = s0;
        al = 2'b01;
      end else if (pos >= R + blank && pos < 2 * R + blank) begin
        sl = s1;
        al = 2'b10;
`ifdef SSD_LEADING_ZERO_BLANK_EN
        if (s1 == 7'b0111111) begin
          sl = 7'h00;
          al = 2'b00;
        end
`endif
      end
      et = (pos == fr - 1);
      ph = (ph + 1) % fr;
    end
    es = seg_al ? ~sl : sl;
    ea = an_al ? ~al : al;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_seg_a"}, 32'(seg_a), 32'h7F);
    check({tag, "_an_a"}, 32'(an_a), 32'h3);
    check({tag, "_tick_a"}, 32'(tick_a), 32'h0);
    check({tag, "_seg_b"}, 32'(seg_b), 32'h00);
    check({tag, "_an_b"}, 32'(an_b), 32'h0);
    check({tag, "_tick_b"}, 32'(tick_b), 32'h0);
  endtask

  task automatic reset_models();
    ph_a = 0; ph_b = 0;
    s0_a = 7'h00; s1_a = 7'h00; s0_b = 7'h00; s1_b = 7'h00;
  endtask

  initial begin
    #2 rst = 1'b0;
    #1 check_reset("por");
    reset_models();
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      if (i == 301 || (i > 20 && $urandom_range(0, 149) == 0)) begin
        #2 rst = 1'b0;
        #1 check_reset("async_rst");
        reset_models();
        @(posedge clk);
        #1 check_reset("held_rst");
        @(negedge clk);
        rst = 1'b1;
      end
      if (i < 40) en = 1'b1;
      else en = ($urandom_range(0, 24) != 0);
      display   = 7'($urandom);
      display_1 = ($urandom_range(0, 3) == 0) ? 7'b0111111 : 7'($urandom);

      @(posedge clk);
      model_step(B0, 1'b1, 1'b1, ph_a, s0_a, s1_a, es_a, ea_a, et_a);
      model_step(B1, 1'b0, 1'b0, ph_b, s0_b, s1_b, es_b, ea_b, et_b);
      #1;
      check("seg_a", 32'(seg_a), 32'(es_a));
      check("an_a", 32'(an_a), 32'(ea_a));
      check("tick_a", 32'(tick_a), 32'(et_a));
      check("seg_b", 32'(seg_b), 32'(es_b));
      check("an_b", 32'(an_b), 32'(ea_b));
      check("tick_b", 32'(tick_b), 32'(et_b));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
